alu_cmd_sequencer: RTL and testbench
====================================

# alu_cmd_sequencer

Command-issue stage that sits directly upstream of the 8-bit combinational ALU. It buffers operand/opcode commands from a valid/ready source in a small FIFO and drives the ALU's operand and select inputs from the FIFO head. It captures the ALU's result and carry into a one-entry output register, which is offered downstream on a second valid/ready interface. Optional result chaining feeds the previous result back as operand A, giving single-cycle-per-op accumulate sequences.

## Interface
- DEPTH, 4, command FIFO entries; power of two, ≥2
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at clk edge
- cmd_op  in  3  ALU select code: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 NOR, 110 SLT, 111 SHL1
- cmd_a  in  8  operand A
- cmd_b  in  8  operand B
- cmd_chain  in  1  1 = replace A with last captured result at execute time
- alu_a  out  8  to ALU A
- alu_b  out  8  to ALU B
- alu_sel  out  3  to ALU select
- alu_out  in  8  from ALU result
- alu_carry  in  1  from ALU carry/borrow
- res_valid  out  1  result register holds data
- res_ready  in  1  downstream accepts result
- res_data  out  8  captured result
- res_carry  out  1  captured carry
- count  out  clog2(DEPTH+1)  FIFO occupancy
- busy  out  1  count != 0 or res_valid

## Operation
- FIFO entry = {op, a, b, chain}; pushed on cmd_valid && cmd_ready; cmd_ready = (count < DEPTH); no fall-through when full, even if a pop occurs in the same cycle.
- ALU drive (combinational from head): alu_sel = head.op; alu_b = head.b; alu_a = head.chain ? last_res : head.a. FIFO empty → alu_a = alu_b = 0, alu_sel = 000.
- Execute (pop) condition: count != 0 && (!res_valid || res_ready). On pop: res_data ← alu_out, res_carry ← alu_carry, last_res ← alu_out, res_valid ← 1.
- Drain without pop: res_valid && res_ready && count == 0 → res_valid ← 0. res_data/res_carry hold their stale values.
- last_res persists across drains; it updates only on execute.
- Simultaneous push and pop: count unchanged; pointers both advance.
- FSM state (derived, exposed for coverage):
  - IDLE: count == 0, !res_valid.
  - RUN: execute this cycle.
  - STALL: res_valid, !res_ready, count != 0.
  - DRAIN: res_valid, count == 0.
  - IDLE→RUN on first push.
  - RUN→STALL when res_ready is low and count != 0.
  - STALL→RUN when res_ready rises.
  - RUN/STALL→DRAIN when the FIFO empties.
  - DRAIN→IDLE on handshake.
- Width rules: all data is 8-bit, with no extension by this block. Carry semantics are those of the ALU (SUB carry = 9th bit of A−B, i.e. 1 on borrow).
- Pointers wrap modulo DEPTH; count saturates at DEPTH via cmd_ready.

## Timing
- Reset (rst_n low, asynchronous): count = 0, FIFO pointers = 0, res_valid = 0, res_data = 0, res_carry = 0, last_res = 0. Consequently cmd_ready = 1, busy = 0, alu_* = 0. Reset mid-operation discards all queued commands and any pending result.
- Deassertion is sampled synchronously; first push is possible on the first edge with rst_n high.
- Latency: command pushed at edge N into an empty FIFO with a free result register → executes at edge N+1 → res_valid high after N+1.
- Throughput: 1 result/cycle while res_ready is held high.
- Chained command immediately following its producer sees the updated last_res, since the producer's pop precedes the dependent's execute by ≥1 edge.
- res_data/res_carry are stable while res_valid && !res_ready.

## Test plan
- Reset then ADD a=200, b=100 with res_ready=1 → res_valid 2 edges after push; res_data=44 (0x2C), res_carry=1; busy returns to 0.
- SUB a=5, b=7 → res_data=0xFE, res_carry=1. SLT a=3, b=9 → 0x01, carry 0. SHL1 a=0x81 → 0x02, carry 0.
- Chain: ADD 3,4 (chain=0), then ADD x,10 (chain=1), then XOR x,0xFF (chain=1) → results 7, 17, 0xEE in order on consecutive cycles.
- Backpressure, DEPTH=4, res_ready=0, six back-to-back pushes:
  - 1st command executes into the result register; next 4 fill the FIFO (count=4).
  - cmd_ready drops and the 6th command is held.
  - Raising res_ready delivers results in order, 1/cycle, with the 6th command accepted once count < 4.
- Simultaneous push/pop at count=2 → count stays 2; wrap-around over ≥3×DEPTH commands preserves order.
- Assert rst_n low asynchronously mid-STALL with count=3 → immediately res_valid=0, count=0, cmd_ready=1, last_res=0. A subsequent chained ADD x,5 → 5.

Source files
------------

// File: rtl/alu_cmd_sequencer_if.sv
// Command payload type and the bus bundle between the sequencer, its command
// source, the combinational ALU and the result consumer.

package alu_cmd_sequencer_pkg;

    // One queued command as stored in the FIFO.
    typedef struct packed {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic       chain;
    } cmd_t;

endpackage

interface alu_cmd_sequencer_if;

    // Command source (valid/ready)
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [7:0] cmd_a;
    logic [7:0] cmd_b;
    logic       cmd_chain;

    // Combinational ALU hookup
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [2:0] alu_sel;
    logic [7:0] alu_out;
    logic       alu_carry;

    // Result consumer (valid/ready)
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_data;
    logic       res_carry;

    // Sequencer side
    modport master (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_chain,
        input  alu_out, alu_carry,
        input  res_ready,
        output cmd_ready,
        output alu_a, alu_b, alu_sel,
        output res_valid, res_data, res_carry
    );

    // Environment side: command source, ALU and result consumer
    modport slave (
        output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_chain,
        output alu_out, alu_carry,
        output res_ready,
        input  cmd_ready,
        input  alu_a, alu_b, alu_sel,
        input  res_valid, res_data, res_carry
    );

endinterface

// File: rtl/alu_cmd_sequencer.sv
// Command-issue stage in front of an 8-bit combinational ALU: command FIFO,
// ALU drive from the FIFO head, one-entry result register with optional
// chaining of the previous result into operand A.

module alu_cmd_sequencer
    import alu_cmd_sequencer_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    alu_cmd_sequencer_if.master          bus,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         busy,
    output logic [1:0]                   state
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_STALL = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    cmd_t            mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   count_next;
    logic            res_valid_q;
    logic            res_valid_next;
    logic [7:0]      res_data_q;
    logic            res_carry_q;
    logic [7:0]      last_res;
    cmd_t            head;
    cmd_t            cmd_in;
    logic            fifo_empty;
    logic            push;
    logic            pop;
    state_t          state_q;
    state_t          state_d;

    assign fifo_empty = (count_q == '0);
    assign head       = mem[rd_ptr];
    assign cmd_in     = '{op: bus.cmd_op, a: bus.cmd_a, b: bus.cmd_b, chain: bus.cmd_chain};

    // Handshakes: a full FIFO refuses commands even if it pops this cycle
    assign bus.cmd_ready = (count_q < CW'(DEPTH));
    assign push          = bus.cmd_valid && bus.cmd_ready;
    assign pop           = !fifo_empty && (!res_valid_q || bus.res_ready);

    // ALU operands come straight from the FIFO head; chained ops take the last result as A
    always_comb begin
        bus.alu_a   = 8'd0;
        bus.alu_b   = 8'd0;
        bus.alu_sel = 3'b000;
        if (!fifo_empty) begin
            bus.alu_a   = head.chain ? last_res : head.a;
            bus.alu_b   = head.b;
            bus.alu_sel = head.op;
        end
    end

    // Next occupancy and result-register valid
    always_comb begin
        count_next     = count_q;
        res_valid_next = res_valid_q;
        if (push && !pop) begin
            count_next = count_q + CW'(1);
        end else if (pop && !push) begin
            count_next = count_q - CW'(1);
        end
        if (pop) begin
            res_valid_next = 1'b1;
        end else if (res_valid_q && bus.res_ready) begin
            res_valid_next = 1'b0;
        end
    end

    // Command storage; entries need no reset since occupancy gates every read
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= cmd_in;
        end
    end

    // Pointers, occupancy and result capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= 8'd0;
            res_carry_q <= 1'b0;
            last_res    <= 8'd0;
        end else begin
            count_q     <= count_next;
            res_valid_q <= res_valid_next;
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr      <= rd_ptr + PW'(1);
                res_data_q  <= bus.alu_out;
                res_carry_q <= bus.alu_carry;
                last_res    <= bus.alu_out;
            end
        end
    end

    // Activity state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Classify the upcoming cycle from next occupancy, result valid and current backpressure
    always_comb begin
        state_d = state_q;
        if (count_next == '0) begin
            state_d = res_valid_next ? S_DRAIN : S_IDLE;
        end else if (res_valid_next && !bus.res_ready) begin
            state_d = S_STALL;
        end else begin
            state_d = S_RUN;
        end
    end

    assign count         = count_q;
    assign busy          = !fifo_empty || res_valid_q;
    assign state         = state_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_carry = res_carry_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer with a behavioural 8-bit ALU.

module tb_alu_cmd_sequencer;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = $clog2(DEPTH + 1);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOR = 3'b101;
    localparam logic [2:0] OP_SLT = 3'b110;
    localparam logic [2:0] OP_SHL = 3'b111;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_STALL = 2'd2;

    logic          clk;
    logic          rst_n;
    logic [CW-1:0] count;
    logic          busy;
    logic [1:0]    state;
    logic [8:0]    alu_wide;

    int checks   = 0;
    int failures = 0;

    alu_cmd_sequencer_if bus();

    alu_cmd_sequencer #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .count (count),
        .busy  (busy),
        .state (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU
    always_comb begin
        alu_wide = 9'd0;
        case (bus.alu_sel)
            OP_ADD: alu_wide = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
            OP_SUB: alu_wide = {1'b0, bus.alu_a} - {1'b0, bus.alu_b};
            OP_AND: alu_wide = {1'b0, bus.alu_a & bus.alu_b};
            OP_OR:  alu_wide = {1'b0, bus.alu_a | bus.alu_b};
            OP_XOR: alu_wide = {1'b0, bus.alu_a ^ bus.alu_b};
            OP_NOR: alu_wide = {1'b0, ~(bus.alu_a | bus.alu_b)};
            OP_SLT: alu_wide = {1'b0, ($signed(bus.alu_a) < $signed(bus.alu_b)) ? 8'd1 : 8'd0};
            default: alu_wide = {1'b0, bus.alu_a[6:0], 1'b0};
        endcase
    end
    assign bus.alu_out   = alu_wide[7:0];
    assign bus.alu_carry = alu_wide[8];

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic       chain;
        logic [7:0] exp_d;
        logic       exp_c;
    } vec_t;

    localparam int NV = 10;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                           input logic chain);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        bus.cmd_chain = chain;
    endtask

    // Stream ADD i*3,7 commands; mode 1 toggles res_ready. Results must come back in order.
    task automatic stream(input string name, input int n, input int mode);
        int sent = 0;
        int got  = 0;
        int cyc  = 0;
        logic hs_c;
        logic hs_r;
        while (got < n && cyc < 400) begin
            bus.cmd_valid = (sent < n);
            bus.cmd_op    = OP_ADD;
            bus.cmd_a     = 8'(sent * 3);
            bus.cmd_b     = 8'd7;
            bus.cmd_chain = 1'b0;
            bus.res_ready = (mode == 0) ? 1'b1 : ((cyc % 3) != 1);
            hs_c = bus.cmd_valid && bus.cmd_ready;
            hs_r = bus.res_valid && bus.res_ready;
            if (hs_r) begin
                check($sformatf("%s_res%0d", name, got), 32'(bus.res_data), 32'(got * 3 + 7));
                got++;
            end
            if (hs_c) sent++;
            step();
            cyc++;
        end
        bus.cmd_valid = 1'b0;
        check($sformatf("%s_count_delivered", name), 32'(got), 32'(n));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic hs_c;
        logic hs_r;
        int   got;
        int   cyc;

        vecs[0] = '{OP_ADD, 8'd200, 8'd100, 1'b0, 8'h2C, 1'b1};
        vecs[1] = '{OP_SUB, 8'd5,   8'd7,   1'b0, 8'hFE, 1'b1};
        vecs[2] = '{OP_SLT, 8'd3,   8'd9,   1'b0, 8'h01, 1'b0};
        vecs[3] = '{OP_SHL, 8'h81,  8'h00,  1'b0, 8'h02, 1'b0};
        vecs[4] = '{OP_AND, 8'hF0,  8'h3C,  1'b0, 8'h30, 1'b0};
        vecs[5] = '{OP_OR,  8'hF0,  8'h0F,  1'b0, 8'hFF, 1'b0};
        vecs[6] = '{OP_XOR, 8'hAA,  8'hFF,  1'b0, 8'h55, 1'b0};
        vecs[7] = '{OP_NOR, 8'h0F,  8'hF0,  1'b0, 8'h00, 1'b0};
        vecs[8] = '{OP_SUB, 8'd9,   8'd4,   1'b0, 8'h05, 1'b0};
        vecs[9] = '{OP_ADD, 8'h77,  8'd1,   1'b1, 8'h06, 1'b0};

        rst_n         = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 3'b000;
        bus.cmd_a     = 8'd0;
        bus.cmd_b     = 8'd0;
        bus.cmd_chain = 1'b0;
        bus.res_ready = 1'b1;
        step();
        step();

        // Reset state
        check("rst_count",     32'(count),         32'd0);
        check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("rst_busy",      32'(busy),          32'd0);
        check("rst_res_valid", 32'(bus.res_valid), 32'd0);
        check("rst_res_data",  32'(bus.res_data),  32'd0);
        check("rst_alu_a",     32'(bus.alu_a),     32'd0);
        check("rst_state",     32'(state),         32'(ST_IDLE));
        rst_n = 1'b1;

        // Single commands, one at a time, consumer always ready
        for (int i = 0; i < NV; i++) begin
            set_cmd(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].chain);
            step();
            bus.cmd_valid = 1'b0;
            check($sformatf("vec%0d_count", i), 32'(count), 32'd1);
            step();
            check($sformatf("vec%0d_valid", i), 32'(bus.res_valid), 32'd1);
            check($sformatf("vec%0d_data", i),  32'(bus.res_data),  32'(vecs[i].exp_d));
            check($sformatf("vec%0d_carry", i), 32'(bus.res_carry), 32'(vecs[i].exp_c));
            step();
            check($sformatf("vec%0d_busy", i),  32'(busy),          32'd0);
        end

        // Chained accumulate on consecutive cycles: 7, 17, 0xEE
        set_cmd(OP_ADD, 8'd3, 8'd4, 1'b0);
        step();
        set_cmd(OP_ADD, 8'd0, 8'd10, 1'b1);
        step();
        check("chain_r0", 32'(bus.res_data), 32'h07);
        set_cmd(OP_XOR, 8'd0, 8'hFF, 1'b1);
        step();
        check("chain_r1", 32'(bus.res_data), 32'h11);
        bus.cmd_valid = 1'b0;
        step();
        check("chain_r2", 32'(bus.res_data), 32'hEE);
        step();
        check("chain_idle", 32'(busy), 32'd0);

        // Backpressure: six pushes with consumer stalled
        bus.res_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            set_cmd(OP_ADD, 8'(i), 8'd0, 1'b0);
            step();
        end
        check("bp_count_full", 32'(count),         32'd4);
        check("bp_cmd_ready",  32'(bus.cmd_ready), 32'd0);
        check("bp_state",      32'(state),         32'(ST_STALL));
        set_cmd(OP_ADD, 8'd6, 8'd0, 1'b0);
        step();
        check("bp_sixth_held", 32'(count),         32'd4);
        check("bp_stable",     32'(bus.res_data),  32'd1);
        bus.res_ready = 1'b1;
        got = 0;
        cyc = 0;
        while (got < 6 && cyc < 40) begin
            hs_c = bus.cmd_valid && bus.cmd_ready;
            hs_r = bus.res_valid && bus.res_ready;
            if (hs_r) begin
                check($sformatf("bp_res%0d", got), 32'(bus.res_data), 32'(got + 1));
                got++;
            end
            step();
            if (hs_c) bus.cmd_valid = 1'b0;
            cyc++;
        end
        check("bp_delivered", 32'(got), 32'd6);
        check("bp_cyc", 32'(cyc), 32'd6);
        step();
        check("bp_idle", 32'(busy), 32'd0);

        // Simultaneous push and pop at count 2
        bus.res_ready = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            set_cmd(OP_ADD, 8'(i), 8'd0, 1'b0);
            step();
        end
        check("pp_count_before", 32'(count), 32'd2);
        set_cmd(OP_ADD, 8'd4, 8'd0, 1'b0);
        bus.res_ready = 1'b1;
        step();
        bus.cmd_valid = 1'b0;
        check("pp_count_after", 32'(count),        32'd2);
        check("pp_res2",        32'(bus.res_data), 32'd2);
        step();
        check("pp_res3",        32'(bus.res_data), 32'd3);
        step();
        check("pp_res4",        32'(bus.res_data), 32'd4);
        step();
        check("pp_idle",        32'(busy),         32'd0);

        // Pointer wrap and throughput over many commands
        stream("wrap", 3 * DEPTH + 2, 1);
        stream("tput", 8, 0);
        step();
        step();

        // Asynchronous reset in the middle of a stall
        bus.res_ready = 1'b0;
        set_cmd(OP_ADD, 8'd10, 8'd20, 1'b0);
        step();
        for (int i = 1; i <= 3; i++) begin
            set_cmd(OP_ADD, 8'(i), 8'(i), 1'b0);
            step();
        end
        bus.cmd_valid = 1'b0;
        check("rs_count_before", 32'(count),        32'd3);
        check("rs_state_before", 32'(state),        32'(ST_STALL));
        check("rs_data_before",  32'(bus.res_data), 32'd30);
        #2;
        rst_n = 1'b0;
        #1;
        check("rs_res_valid", 32'(bus.res_valid), 32'd0);
        check("rs_count",     32'(count),         32'd0);
        check("rs_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("rs_busy",      32'(busy),          32'd0);
        check("rs_alu_a",     32'(bus.alu_a),     32'd0);
        step();
        rst_n = 1'b1;
        bus.res_ready = 1'b1;
        set_cmd(OP_ADD, 8'h99, 8'd5, 1'b1);
        step();
        bus.cmd_valid = 1'b0;
        step();
        check("rs_chain_valid", 32'(bus.res_valid), 32'd1);
        check("rs_chain_data",  32'(bus.res_data),  32'd5);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
